dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single byte-addressed data memory (word/half/byte access, 32-bit data) between two requesters.
//  The requesters are the instruction-fetch unit (IF, word reads only) and the load/store unit (LS, reads and writes).
//  Sequences one memory access per cycle, latches request fields at grant, registers read data, and rejects misaligned or out-of-range LS accesses.
//  Sits between the core pipeline and the data memory; the memory's read path is combinational and its write commits on posedge clk.
// PARAMETERS
//  MEM_BYTES     64  memory size in bytes; addresses >= MEM_BYTES are illegal
//  ADDR_W        8   address width
//  MAX_LS_BURST  2   max consecutive LS grants while IF is requesting (starvation guard)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous reset, active-high
//  if_req     in   1       IF word-read request
//  if_addr    in   ADDR_W  IF byte address
//  if_gnt     out  1       IF request accepted this cycle (access in progress)
//  if_rvalid  out  1       if_rdata valid, 1-cycle pulse
//  if_rdata   out  32      IF read data
//  ls_req     in   1       LS request
//  ls_we      in   1       1 = store, 0 = load
//  ls_size    in   2       00 word, 01 half, 10 byte, 11 illegal
//  ls_signed  in   1       sign-extend loads (half/byte)
//  ls_addr    in   ADDR_W  LS byte address
//  ls_wdata   in   32      store data
//  ls_gnt     out  1       LS request accepted (or rejected, see ls_err)
//  ls_rvalid  out  1       ls_rdata valid (loads only), 1-cycle pulse
//  ls_rdata   out  32      LS load data
//  ls_err     out  1       LS request rejected, 1-cycle pulse with ls_gnt
//  mem_read, mem_write  out 1   memory strobes
//  mem_sel    out  2       size to memory (same encoding as ls_size)
//  mem_signed out  1       sign-extend to memory
//  mem_addr   out  ADDR_W  memory address;  mem_wdata out 32 store data;  mem_rdata in 32 memory read data
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, burst count 0, every output 0 (mem_write drops at once; an uncommitted store is lost).
//  - FSM states IDLE, SERVE_IF, SERVE_LS. Each edge where state is IDLE or SERVE_* is a selection edge:
//    LS wins unless if_req=1 and burst count==MAX_LS_BURST; else IF if if_req; else IDLE.
//  - Burst count: +1 per LS grant while if_req=1, cleared on IF grant or when if_req=0.
//  - At the selection edge the winner's fields are latched; next cycle the FSM is in SERVE_x, x_gnt=1, mem_* driven from the latch.
//  - Requester may change inputs once gnt=1; req still high at the gnt edge is a new request (back-to-back, 1 access/cycle).
//  - IF accesses are always mem_sel=00, mem_signed=0, mem_read=1.
//  - LS load: mem_read=1. LS store: mem_write=1, mem_read=0. Only one strobe is ever high.
//  - Read data is registered at the end of the SERVE cycle: rvalid=1 with rdata in the following cycle (req edge N -> rvalid cycle N+2). rdata holds until the next rvalid.
//  - LS is rejected when size=11, or word with addr[1:0]!=0, or half with addr[0]!=0, or addr+bytes>MEM_BYTES.
//    A rejected request is granted, but there is no memory access and no rvalid; ls_gnt=1 and ls_err=1 for one cycle.
//  - Idle/reject cycles: mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
//  - Rejected requests and their grant cycles count toward the burst limit.
// TESTING
//  1. Reset: assert rst mid-store (SERVE_LS, we=1) -> mem_write=0 immediately, all outputs 0, mem byte unchanged.
//  2. LS word store 0xDEADBEEF @0x04, then LS load word @0x04 -> ls_rvalid 2 cycles after req, ls_rdata=0xDEADBEEF.
//  3. Load byte @0x08 (holds 0xFF): signed -> 0xFFFFFFFF, unsigned -> 0x000000FF; half load @0x08 (0x00FF) signed -> 0x000000FF.
//  4. if_req and ls_req both held high 8 cycles -> grants LS,LS,IF,LS,LS,IF,LS,LS; every grant gives a matching rvalid.
//  5. LS word @0x02, half @0x05, byte @0x40, word @0x3E -> each: ls_gnt=ls_err=1, no mem strobe, no ls_rvalid.
//  6. IF only, if_addr 0x00 then 0x04 back-to-back -> if_gnt 2 consecutive cycles, if_rdata 0x00000001 then 0x00000005.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one byte-addressed data memory between the instruction-fetch unit (IF,
// word reads only) and the load/store unit (LS, loads and stores). One access
// is sequenced per cycle: requests are sampled on a selection edge, the
// winner's fields are latched, and the following cycle (SERVE_IF / SERVE_LS)
// drives the memory from the latch while presenting the grant. Read data is
// registered at the end of the serve cycle, so rvalid appears one cycle after
// the grant. Misaligned, oversize or out-of-range LS requests are granted
// with ls_err and never reach the memory.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   if_req_i/if_addr_i              IF word-read request
//   if_gnt_o/if_rvalid_o/if_rdata_o IF grant, read-data valid pulse, read data
//   ls_req_i/ls_we_i/ls_size_i/ls_signed_i/ls_addr_i/ls_wdata_i  LS request
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o/ls_err_o  LS grant, load valid, data, reject
//   mem_read_o/mem_write_o          memory strobes (never both high)
//   mem_sel_o/mem_signed_o          access size / sign-extension to memory
//   mem_addr_o/mem_wdata_o          memory address and store data
//   mem_rdata_i                     memory read data (combinational)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int MEM_BYTES    = 64,
  parameter int ADDR_W       = 8,
  parameter int MAX_LS_BURST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic              ls_signed_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [1:0]        mem_sel_o,
  output logic              mem_signed_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int CNT_W = (MAX_LS_BURST < 1) ? 1 : $clog2(MAX_LS_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_LS_BURST);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_LS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              if_rvalid_q;
  logic [31:0]       if_rdata_q;
  logic              ls_rvalid_q;
  logic [31:0]       ls_rdata_q;

  logic [2:0]        ls_bytes;
  logic [ADDR_W:0]   ls_end;
  logic              ls_bad;
  logic              ls_wins;

  // LS legality: illegal size, natural misalignment, or running past the end
  // of memory. ls_end is one bit wider than the address so it cannot wrap.
  always_comb begin
    ls_bytes = 3'd0;
    case (ls_size_i)
      2'b00:   ls_bytes = 3'd4;
      2'b01:   ls_bytes = 3'd2;
      2'b10:   ls_bytes = 3'd1;
      default: ls_bytes = 3'd0;
    endcase
    ls_end = {1'b0, ls_addr_i} + {{(ADDR_W - 2){1'b0}}, ls_bytes};
    ls_bad = (ls_size_i == 2'b11)
          || ((ls_size_i == 2'b00) && (ls_addr_i[1:0] != 2'b00))
          || ((ls_size_i == 2'b01) && ls_addr_i[0])
          || (ls_end > MEM_LIMIT);
  end

  // Selection: every edge picks the next access. LS has priority except when
  // IF is waiting and LS has already taken MAX_LS_BURST grants in a row.
  always_comb begin
    state_d  = IDLE;
    burst_d  = '0;
    addr_d   = addr_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    ls_wins  = ls_req_i && !(if_req_i && (burst_q == BURST_MAX));

    if (ls_wins) begin
      state_d  = SERVE_LS;
      // The run only counts while IF is actually being held off.
      burst_d  = if_req_i ? (burst_q + CNT_W'(1)) : '0;
      addr_d   = ls_addr_i;
      we_d     = ls_we_i;
      size_d   = ls_size_i;
      signed_d = ls_signed_i;
      wdata_d  = ls_wdata_i;
      err_d    = ls_bad;
    end else if (if_req_i) begin
      state_d  = SERVE_IF;
      addr_d   = if_addr_i;
      we_d     = 1'b0;
      size_d   = 2'b00;
      signed_d = 1'b0;
      wdata_d  = '0;
      err_d    = 1'b0;
    end
  end

  // Serve-cycle outputs, all decoded from the state and the latched request.
  always_comb begin
    if_gnt_o     = 1'b0;
    ls_gnt_o     = 1'b0;
    ls_err_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_sel_o    = 2'b00;
    mem_signed_o = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      SERVE_IF: begin
        if_gnt_o   = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = addr_q;
      end
      SERVE_LS: begin
        ls_gnt_o = 1'b1;
        if (err_q) begin
          // Rejected: grant handshake only, memory bus stays quiet.
          ls_err_o = 1'b1;
        end else begin
          mem_addr_o   = addr_q;
          mem_sel_o    = size_q;
          mem_signed_o = signed_q;
          if (we_q) begin
            mem_write_o = 1'b1;
            mem_wdata_o = wdata_q;
          end else begin
            mem_read_o = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;

      // Capture read data at the end of the serve cycle; rdata holds
      // its value until the next valid read for that requester.
      if_rvalid_q <= (state_q == SERVE_IF);
      if (state_q == SERVE_IF) begin
        if_rdata_q <= mem_rdata_i;
      end
      ls_rvalid_q <= (state_q == SERVE_LS) && !err_q && !we_q;
      if ((state_q == SERVE_LS) && !err_q && !we_q) begin
        ls_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Drives dmem_port_arbiter against a byte-array memory model. Hand sequences
// cover reset during a store, back-to-back IF reads and the LS/IF burst
// pattern; a vector table covers single LS transactions including rejects;
// a random phase compares every output each cycle against a transaction-level
// reference (arbitration rule, legality rule, shadow memory).
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int MEM_BYTES    = 64;
  localparam int ADDR_W       = 8;
  localparam int MAX_LS_BURST = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req, ls_we, ls_signed;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt, ls_rvalid, ls_err;
  logic [31:0]       ls_rdata;
  logic              mem_read, mem_write, mem_signed;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  dmem_port_arbiter #(
    .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .MAX_LS_BURST(MAX_LS_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size),
    .ls_signed_i(ls_signed), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .ls_err_o(ls_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_sel_o(mem_sel),
    .mem_signed_o(mem_signed), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- memory environment and shadow reference ----------------
  logic [7:0] env_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic int idx(input logic [7:0] a);
    return int'(a) % MEM_BYTES;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   return {b3, b2, b1, b0};
      2'b01:   return sg ? {{16{b1[7]}}, b1, b0} : {16'h0000, b1, b0};
      2'b10:   return sg ? {{24{b0[7]}}, b0} : {24'h000000, b0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    mem_rdata = fmt_load(env_mem[idx(mem_addr)], env_mem[idx(mem_addr + 8'd1)],
                         env_mem[idx(mem_addr + 8'd2)], env_mem[idx(mem_addr + 8'd3)],
                         mem_sel, mem_signed);
  end

  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[idx(mem_addr)] <= mem_wdata[7:0];
      if (mem_sel != 2'b10) env_mem[idx(mem_addr + 8'd1)] <= mem_wdata[15:8];
      if (mem_sel == 2'b00) begin
        env_mem[idx(mem_addr + 8'd2)] <= mem_wdata[23:16];
        env_mem[idx(mem_addr + 8'd3)] <= mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] sz,
                                           input logic sg);
    return fmt_load(ref_mem[idx(a)], ref_mem[idx(a + 8'd1)], ref_mem[idx(a + 8'd2)],
                    ref_mem[idx(a + 8'd3)], sz, sg);
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    ref_mem[idx(a)] = d[7:0];
    if (sz != 2'b10) ref_mem[idx(a + 8'd1)] = d[15:8];
    if (sz == 2'b00) begin
      ref_mem[idx(a + 8'd2)] = d[23:16];
      ref_mem[idx(a + 8'd3)] = d[31:24];
    end
  endtask

  // Legality straight from the access rules: size, natural alignment, bounds.
  function automatic logic ls_illegal(input logic [1:0] sz, input logic [7:0] a);
    int nb;
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    if (sz == 2'b11) return 1'b1;
    if ((int'(a) % nb) != 0) return 1'b1;
    return (int'(a) + nb) > MEM_BYTES;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_if_gnt"}, 32'(if_gnt), 0);
    chk({p, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({p, "_if_rdata"}, if_rdata, 0);
    chk({p, "_ls_gnt"}, 32'(ls_gnt), 0);
    chk({p, "_ls_rvalid"}, 32'(ls_rvalid), 0);
    chk({p, "_ls_rdata"}, ls_rdata, 0);
    chk({p, "_ls_err"}, 32'(ls_err), 0);
    chk({p, "_mem_read"}, 32'(mem_read), 0);
    chk({p, "_mem_write"}, 32'(mem_write), 0);
    chk({p, "_mem_sel"}, 32'(mem_sel), 0);
    chk({p, "_mem_signed"}, 32'(mem_signed), 0);
    chk({p, "_mem_addr"}, 32'(mem_addr), 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // ---------------- LS vector table ----------------
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  logic [31:0] last_if;
  logic [31:0] last_ls;

  // One isolated LS transaction starting at a negedge with the arbiter idle.
  task automatic ls_single(input vec_t v, input int i);
    logic exp_rv;
    exp_rv = !v.we && !v.err;
    ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_signed = v.sgn;
    ls_addr = v.addr; ls_wdata = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 1);
    chk($sformatf("v%0d_ls_err", i), 32'(ls_err), 32'(v.err));
    chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(v.we && !v.err));
    chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(!v.we && !v.err));
    chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), v.err ? 32'h0 : 32'(v.addr));
    if (!v.err) chk($sformatf("v%0d_mem_sel", i), 32'(mem_sel), 32'(v.size));
    if (v.we && !v.err) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.wdata);
    ls_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ls_gnt_off", i), 32'(ls_gnt), 0);
    chk($sformatf("v%0d_ls_rvalid", i), 32'(ls_rvalid), 32'(exp_rv));
    if (exp_rv) last_ls = v.rdata;
    chk($sformatf("v%0d_ls_rdata", i), ls_rdata, last_ls);
    if (v.we && !v.err) ref_write(v.addr, v.size, v.wdata);
    $display("vec %0d: we=%0d size=%0d sgn=%0d addr=0x%02h err=%0d rdata=0x%08h",
             i, v.we, v.size, v.sgn, v.addr, ls_err, ls_rdata);
  endtask

  // ---------------- random-phase expectation record ----------------
  typedef struct packed {
    logic        if_gnt;
    logic        ls_gnt;
    logic        ls_err;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_sel;
    logic        mem_signed;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
  } exp_t;

  initial begin
    exp_t        cur, nx;
    int          consec;
    logic        if_pend, ls_pend, ls_takes;
    logic        prev_if, prev_ls, pat_ls;
    logic [7:0]  burst_pat;
    logic [7:0]  r_if_addr, r_addr;
    logic        r_we, r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [7:0]  b;

    vecs[0]  = mk(1'b1, 2'b00, 1'b0, 8'h04, 32'hDEADBEEF, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 2'b00, 1'b0, 8'h04, 32'h0,        1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b0, 2'b10, 1'b1, 8'h08, 32'h0,        1'b0, 32'hFFFFFFFF);
    vecs[3]  = mk(1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        1'b0, 32'h000000FF);
    vecs[4]  = mk(1'b0, 2'b01, 1'b1, 8'h08, 32'h0,        1'b0, 32'h000000FF);
    vecs[5]  = mk(1'b0, 2'b00, 1'b0, 8'h02, 32'h0,        1'b1, 32'h0);
    vecs[6]  = mk(1'b0, 2'b01, 1'b0, 8'h05, 32'h0,        1'b1, 32'h0);
    vecs[7]  = mk(1'b0, 2'b10, 1'b0, 8'h40, 32'h0,        1'b1, 32'h0);
    vecs[8]  = mk(1'b0, 2'b00, 1'b0, 8'h3E, 32'h0,        1'b1, 32'h0);
    vecs[9]  = mk(1'b1, 2'b11, 1'b0, 8'h00, 32'hCAFEF00D, 1'b1, 32'h0);
    vecs[10] = mk(1'b0, 2'b01, 1'b1, 8'h3E, 32'h0,        1'b0, 32'hFFFF8234);
    vecs[11] = mk(1'b1, 2'b10, 1'b0, 8'h3F, 32'h000000A5, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 2'b10, 1'b0, 8'h3F, 32'h0,        1'b0, 32'h000000A5);
    vecs[13] = mk(1'b0, 2'b01, 1'b0, 8'h3F, 32'h0,        1'b1, 32'h0);
    vecs[14] = mk(1'b1, 2'b00, 1'b0, 8'h3C, 32'h11223344, 1'b0, 32'h0);
    vecs[15] = mk(1'b0, 2'b00, 1'b0, 8'h3C, 32'h0,        1'b0, 32'h11223344);
    vecs[16] = mk(1'b0, 2'b01, 1'b0, 8'h3E, 32'h0,        1'b0, 32'h00001122);
    vecs[17] = mk(1'b1, 2'b00, 1'b0, 8'h40, 32'h55555555, 1'b1, 32'h0);

    // Memory image: random background with fixed cells used by the hand tests.
    for (int i = 0; i < MEM_BYTES; i++) begin
      b = 8'($urandom_range(0, 255));
      env_mem[i] <= b;
      ref_mem[i] = b;
    end
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: b = 8'h01;
        4: b = 8'h05;
        8: b = 8'hFF;
        default: b = 8'h00;
      endcase
      env_mem[i] <= b;
      ref_mem[i] = b;
    end
    env_mem[8'h3E] <= 8'h34; ref_mem[8'h3E] = 8'h34;
    env_mem[8'h3F] <= 8'h82; ref_mem[8'h3F] = 8'h82;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
    ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a store: strobe drops at once, memory untouched.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 8'h10; ls_wdata = 32'h12345678;
    @(negedge clk);
    chk("t1_write_before_rst", 32'(mem_write), 1);
    ls_req = 1'b0; ls_we = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("t1_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_mem_kept%0d", k), 32'(env_mem[16 + k]), 32'(ref_mem[16 + k]));
    $display("txn reset-during-store @0x10: mem_write=%0d", mem_write);
    last_if = 32'h0; last_ls = 32'h0;

    // IF back-to-back word reads.
    if_req = 1'b1; if_addr = 8'h00;
    @(negedge clk);
    chk("t6_gnt0", 32'(if_gnt), 1);
    chk("t6_addr0", 32'(mem_addr), 0);
    chk("t6_read0", 32'(mem_read), 1);
    if_addr = 8'h04;
    @(negedge clk);
    chk("t6_gnt1", 32'(if_gnt), 1);
    chk("t6_addr1", 32'(mem_addr), 32'h04);
    chk("t6_rvalid0", 32'(if_rvalid), 1);
    chk("t6_rdata0", if_rdata, 32'h00000001);
    $display("txn IF read @0x00: rdata=0x%08h", if_rdata);
    if_req = 1'b0;
    @(negedge clk);
    chk("t6_gnt_off", 32'(if_gnt), 0);
    chk("t6_rvalid1", 32'(if_rvalid), 1);
    chk("t6_rdata1", if_rdata, 32'h00000005);
    $display("txn IF read @0x04: rdata=0x%08h", if_rdata);
    @(negedge clk);
    chk("t6_rvalid_off", 32'(if_rvalid), 0);
    chk("t6_rdata_hold", if_rdata, 32'h00000005);
    last_if = 32'h00000005;

    // Table of isolated LS transactions.
    for (int i = 0; i < NVEC; i++) ls_single(vecs[i], i);

    // Both requesters held high: LS,LS,IF repeating.
    burst_pat = 8'b1101_1011;  // bit c set = LS grant in cycle c
    prev_if = 1'b0; prev_ls = 1'b0;
    if_req = 1'b1; if_addr = 8'h00;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_signed = 1'b0; ls_addr = 8'h04;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat_ls = burst_pat[c];
      chk($sformatf("t4_ls_gnt%0d", c), 32'(ls_gnt), 32'(pat_ls));
      chk($sformatf("t4_if_gnt%0d", c), 32'(if_gnt), 32'(!pat_ls));
      chk($sformatf("t4_if_rvalid%0d", c), 32'(if_rvalid), 32'(prev_if));
      chk($sformatf("t4_ls_rvalid%0d", c), 32'(ls_rvalid), 32'(prev_ls));
      if (prev_if) chk($sformatf("t4_if_rdata%0d", c), if_rdata, 32'h00000001);
      if (prev_ls) chk($sformatf("t4_ls_rdata%0d", c), ls_rdata, 32'hDEADBEEF);
      $display("txn burst cycle %0d: grant=%s", c, pat_ls ? "LS" : "IF");
      prev_if = !pat_ls; prev_ls = pat_ls;
      if (c == 7) begin if_req = 1'b0; ls_req = 1'b0; end
    end
    @(negedge clk);
    chk("t4_if_rvalid_last", 32'(if_rvalid), 32'(prev_if));
    chk("t4_ls_rvalid_last", 32'(ls_rvalid), 32'(prev_ls));
    chk("t4_ls_rdata_last", ls_rdata, 32'hDEADBEEF);
    chk("t4_idle_gnt", 32'(if_gnt | ls_gnt), 0);
    last_if = 32'h00000001; last_ls = 32'hDEADBEEF;
    @(negedge clk);

    // Random traffic against the transaction-level reference.
    cur = '0; cur.if_rdata = last_if; cur.ls_rdata = last_ls;
    consec = 0; if_pend = 1'b0; ls_pend = 1'b0;
    r_if_addr = 8'h00; r_addr = 8'h00; r_we = 1'b0; r_sgn = 1'b0; r_size = 2'b00; r_wdata = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk($sformatf("r%0d_if_gnt", cyc), 32'(if_gnt), 32'(cur.if_gnt));
      chk($sformatf("r%0d_ls_gnt", cyc), 32'(ls_gnt), 32'(cur.ls_gnt));
      chk($sformatf("r%0d_ls_err", cyc), 32'(ls_err), 32'(cur.ls_err));
      chk($sformatf("r%0d_mem_read", cyc), 32'(mem_read), 32'(cur.mem_read));
      chk($sformatf("r%0d_mem_write", cyc), 32'(mem_write), 32'(cur.mem_write));
      chk($sformatf("r%0d_mem_addr", cyc), 32'(mem_addr), 32'(cur.mem_addr));
      chk($sformatf("r%0d_mem_wdata", cyc), mem_wdata, cur.mem_wdata);
      if (cur.mem_read | cur.mem_write) begin
        chk($sformatf("r%0d_mem_sel", cyc), 32'(mem_sel), 32'(cur.mem_sel));
        chk($sformatf("r%0d_mem_signed", cyc), 32'(mem_signed), 32'(cur.mem_signed));
      end
      chk($sformatf("r%0d_if_rvalid", cyc), 32'(if_rvalid), 32'(cur.if_rvalid));
      chk($sformatf("r%0d_if_rdata", cyc), if_rdata, cur.if_rdata);
      chk($sformatf("r%0d_ls_rvalid", cyc), 32'(ls_rvalid), 32'(cur.ls_rvalid));
      chk($sformatf("r%0d_ls_rdata", cyc), ls_rdata, cur.ls_rdata);

      if (cur.if_gnt) if_pend = 1'b0;
      if (cur.ls_gnt) ls_pend = 1'b0;
      if (!if_pend && ($urandom_range(0, 99) < 55)) begin
        if_pend = 1'b1;
        r_if_addr = 8'(4 * $urandom_range(0, 15));
      end
      if (!ls_pend && ($urandom_range(0, 99) < 65)) begin
        ls_pend = 1'b1;
        r_we    = 1'($urandom_range(0, 1));
        r_size  = 2'($urandom_range(0, 3));
        r_sgn   = 1'($urandom_range(0, 1));
        r_addr  = 8'($urandom_range(0, 71));
        r_wdata = $urandom;
      end
      if_req = if_pend; if_addr = r_if_addr;
      ls_req = ls_pend; ls_we = r_we; ls_size = r_size; ls_signed = r_sgn;
      ls_addr = r_addr; ls_wdata = r_wdata;

      // What the current cycle's access produces, then who owns the next one.
      nx = '0;
      nx.if_rdata = cur.if_rdata;
      nx.ls_rdata = cur.ls_rdata;
      if (cur.if_gnt) begin
        nx.if_rvalid = 1'b1;
        nx.if_rdata  = ref_read(cur.mem_addr, 2'b00, 1'b0);
      end
      if (cur.ls_gnt && cur.mem_read) begin
        nx.ls_rvalid = 1'b1;
        nx.ls_rdata  = ref_read(cur.mem_addr, cur.mem_sel, cur.mem_signed);
      end
      if (cur.mem_write) ref_write(cur.mem_addr, cur.mem_sel, cur.mem_wdata);

      ls_takes = ls_pend && !(if_pend && (consec >= MAX_LS_BURST));
      if (ls_takes) begin
        consec = if_pend ? consec + 1 : 0;
        nx.ls_gnt = 1'b1;
        if (ls_illegal(r_size, r_addr)) begin
          nx.ls_err = 1'b1;
        end else begin
          nx.mem_addr   = r_addr;
          nx.mem_sel    = r_size;
          nx.mem_signed = r_sgn;
          if (r_we) begin
            nx.mem_write = 1'b1;
            nx.mem_wdata = r_wdata;
          end else begin
            nx.mem_read = 1'b1;
          end
        end
        $display("rand %0d: LS we=%0d size=%0d addr=0x%02h err=%0d", cyc, r_we, r_size, r_addr, nx.ls_err);
      end else begin
        consec = 0;
        if (if_pend) begin
          nx.if_gnt   = 1'b1;
          nx.mem_read = 1'b1;
          nx.mem_addr = r_if_addr;
          $display("rand %0d: IF addr=0x%02h", cyc, r_if_addr);
        end
      end
      cur = nx;
      @(negedge clk);
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
